// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the pipelined FP32 multiplier.
// Field widths, biases, the canonical quiet NaN and an operand classifier.
package fp32_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned EXPS_W  = 10;
  localparam int unsigned PROD_W  = 48;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned LATENCY = 4;
  localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  // Denormals have a zero exponent and are therefore reported as zero.
  function automatic fp_class_t classify(input fp32_t x);
    fp_class_t c;
    c.zero = (x.exp == '0);
    c.inf  = (x.exp == '1) && (x.man == '0);
    c.nan  = (x.exp == '1) && (x.man != '0);
    return c;
  endfunction

endpackage

// File: rtl/fp32_mult_pipelined_if.sv
// Operand/result bundle for fp32_mult_pipelined; master drives operands.
interface fp32_mult_pipelined_if;
  import fp32_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             overflow;
  logic             underflow;

  modport master (output start, a, b, input result, done, overflow, underflow);
  modport slave  (input start, a, b, output result, done, overflow, underflow);
endinterface

// File: rtl/fp32_round_ne.sv
// Normalizes a 48-bit significand product and rounds to nearest, ties to even.
module fp32_round_ne
  import fp32_pkg::*;
(
  input  logic        [PROD_W-1:0] prod_i,
  input  logic signed [EXPS_W-1:0] exp_i,
  output logic        [MAN_W-1:0]  man_o,
  output logic signed [EXPS_W-1:0] exp_o
);
  logic [MAN_W-1:0]         man_pre;
  logic                     guard, rnd, sticky, up;
  logic signed [EXPS_W-1:0] exp_n;
  logic [MAN_W:0]           sum;

  always_comb begin
    if (prod_i[47]) begin
      man_pre = prod_i[46:24];
      guard   = prod_i[23];
      rnd     = prod_i[22];
      sticky  = |prod_i[21:0];
      exp_n   = exp_i + 10'sd1;
    end else begin
      man_pre = prod_i[45:23];
      guard   = prod_i[22];
      rnd     = prod_i[21];
      sticky  = |prod_i[20:0];
      exp_n   = exp_i;
    end
    up    = guard & (rnd | sticky | man_pre[0]);
    sum   = {1'b0, man_pre} + {{MAN_W{1'b0}}, up};
    // A carry out means the significand wrapped to 1.0; the mantissa is already zero.
    man_o = sum[MAN_W-1:0];
    exp_o = sum[MAN_W] ? exp_n + 10'sd1 : exp_n;
  end
endmodule

// File: rtl/fp32_mult_pipelined.sv
// Four-stage binary32 multiplier: one pair per cycle, flush-to-zero, RNE rounding.
module fp32_mult_pipelined
  import fp32_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  fp32_mult_pipelined_if.slave bus
);
  logic                     v0_q, v1_q, v2_q, v3_q;
  fp32_t                    a0_q, b0_q;
  logic                     sa1_q, sb1_q, s2_q, s3_q;
  logic [EXP_W-1:0]         ea1_q, eb1_q;
  logic [MAN_W:0]           ma1_q, mb1_q;
  fp_class_t                ca, cb, cls1_d, cls1_q, cls2_q, cls3_q;
  logic signed [EXPS_W-1:0] e2_d, e2_q, e3_d, e3_q;
  logic [PROD_W-1:0]        p2_d, p2_q;
  logic [MAN_W-1:0]         m3_d, m3_q;
  logic [WIDTH-1:0]         result_d, result_q;
  logic                     ovf_d, ovf_q, unf_d, unf_q, done_q;

  always_comb begin
    ca = classify(a0_q);
    cb = classify(b0_q);
    cls1_d.nan  = ca.nan | cb.nan | (ca.inf & cb.zero) | (ca.zero & cb.inf);
    cls1_d.inf  = ca.inf | cb.inf;
    cls1_d.zero = ca.zero | cb.zero;
  end

  always_comb begin
    e2_d = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - $signed(10'(BIAS));
    p2_d = PROD_W'(ma1_q) * PROD_W'(mb1_q);
  end

  fp32_round_ne u_round (
    .prod_i (p2_q),
    .exp_i  (e2_q),
    .man_o  (m3_d),
    .exp_o  (e3_d)
  );

  // Special operands take priority over range checks; bubbles hold the last result.
  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (v3_q) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (cls3_q.nan) begin
        result_d = QNAN;
      end else if (cls3_q.inf) begin
        result_d = {s3_q, 8'hFF, 23'h0};
      end else if (cls3_q.zero) begin
        result_d = {s3_q, 31'h0};
      end else if (e3_q >= $signed(10'(EXP_MAX))) begin
        result_d = {s3_q, 8'hFF, 23'h0};
        ovf_d    = 1'b1;
      end else if (e3_q <= 10'sd0) begin
        result_d = {s3_q, 31'h0};
        unf_d    = 1'b1;
      end else begin
        result_d = {s3_q, e3_q[EXP_W-1:0], m3_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q     <= 1'b0;
      a0_q     <= '0;
      b0_q     <= '0;
      v1_q     <= 1'b0;
      sa1_q    <= 1'b0;
      sb1_q    <= 1'b0;
      ea1_q    <= '0;
      eb1_q    <= '0;
      ma1_q    <= '0;
      mb1_q    <= '0;
      cls1_q   <= '0;
      v2_q     <= 1'b0;
      s2_q     <= 1'b0;
      e2_q     <= '0;
      p2_q     <= '0;
      cls2_q   <= '0;
      v3_q     <= 1'b0;
      s3_q     <= 1'b0;
      e3_q     <= '0;
      m3_q     <= '0;
      cls3_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      v0_q     <= bus.start;
      a0_q     <= bus.a;
      b0_q     <= bus.b;
      v1_q     <= v0_q;
      sa1_q    <= a0_q.sign;
      sb1_q    <= b0_q.sign;
      ea1_q    <= a0_q.exp;
      eb1_q    <= b0_q.exp;
      ma1_q    <= {1'b1, a0_q.man};
      mb1_q    <= {1'b1, b0_q.man};
      cls1_q   <= cls1_d;
      v2_q     <= v1_q;
      s2_q     <= sa1_q ^ sb1_q;
      e2_q     <= e2_d;
      p2_q     <= p2_d;
      cls2_q   <= cls1_q;
      v3_q     <= v2_q;
      s3_q     <= s2_q;
      e3_q     <= e3_d;
      m3_q     <= m3_d;
      cls3_q   <= cls2_q;
      result_q <= result_d;
      done_q   <= v3_q;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_fp32_mult_pipelined.sv
// Self-checking bench for fp32_mult_pipelined: directed table, random stream, reset abort.
module tb_fp32_mult_pipelined;
  import fp32_pkg::*;

  typedef struct {
    logic [31:0] a, b, r;
    logic        o, u;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic        o, u;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  fp32_mult_pipelined_if bus();

  fp32_mult_pipelined dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        sbq[$];
  exp_t        last;
  vec_t        tbl[18];

  // Exact integer product, then round-to-nearest-even by comparing the discarded remainder to half an ulp.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, k, sh, e;
    logic        s, an, ai, az, bn, bi, bz;
    logic [63:0] p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (az && bi)) return {32'h7FC00000, 2'b00};
    if (ai || bi) return {s, 8'hFF, 23'h0, 2'b00};
    if (az || bz) return {s, 31'h0, 2'b00};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    k = 63;
    while (p[k] == 1'b0) k--;
    sh   = k - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      sh = sh + 1;
    end
    e = ea + eb - 127 + sh - 23;
    if (e >= 255) return {s, 8'hFF, 23'h0, 2'b10};
    if (e <= 0) return {s, 31'h0, 2'b01};
    return {s, 8'(e), q[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom();
    case ($urandom_range(0, 15))
      0:       x[30:23] = 8'h00;
      1:       begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
      2:       x[30:23] = 8'hFF;
      3, 4:    ;
      5:       x[30:23] = 8'($urandom_range(190, 254));
      6:       x[30:23] = 8'($urandom_range(1, 64));
      default: x[30:23] = 8'($urandom_range(100, 154));
    endcase
    return x;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sbq.size() <= LATENCY) return;
    e = sbq.pop_front();
    n_cmp++;
    if (bus.done !== e.v) begin
      n_bad++;
      $display("FAIL done @%0t: got %b want %b", $time, bus.done, e.v);
    end
    if (e.v) last = e;
    n_cmp++;
    if ({bus.result, bus.overflow, bus.underflow} !== {last.r, last.o, last.u}) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h ov=%b un=%b want %h ov=%b un=%b",
               e.v ? "result" : "hold", $time, bus.result, bus.overflow, bus.underflow,
               last.r, last.o, last.u);
    end
  endtask

  task automatic step_vec(input logic st, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic o, input logic u);
    exp_t e;
    @(negedge clk);
    check_out();
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    e.v = st; e.r = r; e.o = o; e.u = u;
    sbq.push_back(e);
  endtask

  task automatic step_rand(input logic st, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] m;
    m = ref_mul(a, b);
    step_vec(st, a, b, m[33:2], m[1], m[0]);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({bus.result, bus.done, bus.overflow, bus.underflow} !== 35'h0) begin
      n_bad++;
      $display("FAIL %s @%0t: got r=%h d=%b ov=%b un=%b want all zero", name, $time,
               bus.result, bus.done, bus.overflow, bus.underflow);
    end
  endtask

  task automatic do_reset();
    exp_t z;
    z.v = 1'b0; z.r = 32'h0; z.o = 1'b0; z.u = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    sbq.delete();
    last = z;
    repeat (LATENCY + 1) sbq.push_back(z);
  endtask

  initial begin
    tbl[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    tbl[1]  = '{32'h40400000, 32'hBF000000, 32'hBFC00000, 1'b0, 1'b0};
    tbl[2]  = '{32'h3F800000, 32'h3F800001, 32'h3F800001, 1'b0, 1'b0};
    tbl[3]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0};
    tbl[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
    tbl[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    tbl[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
    tbl[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
    tbl[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0};
    tbl[9]  = '{32'h007FFFFF, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    tbl[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0};
    tbl[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0};
    tbl[12] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0};
    tbl[13] = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0};
    tbl[14] = '{32'h3F000000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    tbl[15] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0};
    tbl[16] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0};
    tbl[17] = '{32'h3F800000, 32'h00800000, 32'h00800000, 1'b0, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    #1;
    check_zero("reset_state");
    do_reset();

    // Single isolated pair, then the rest of the table back-to-back.
    step_vec(1'b1, tbl[0].a, tbl[0].b, tbl[0].r, tbl[0].o, tbl[0].u);
    repeat (5) step_rand(1'b0, rand_op(), rand_op());
    for (int i = 1; i < 18; i++) step_vec(1'b1, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].o, tbl[i].u);
    repeat (3) step_rand(1'b0, rand_op(), rand_op());

    repeat (400) step_rand($urandom_range(0, 3) != 0, rand_op(), rand_op());

    // Two pairs in flight when reset hits: outputs clear at once and neither pair completes.
    step_vec(1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    step_vec(1'b1, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0);
    step_rand(1'b0, 32'h0, 32'h0);
    step_rand(1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    do_reset();
    repeat (8) step_rand(1'b0, rand_op(), rand_op());

    repeat (60) step_rand($urandom_range(0, 1) != 0, rand_op(), rand_op());
    repeat (LATENCY + 1) step_rand(1'b0, rand_op(), rand_op());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp32_mult_pipelined.md
FP32_MULT_PIPELINED -- requirements
Module: fp32_mult_pipelined

Interface
REQ-001 Parameters: none; the pipeline depth is a fixed constant LATENCY = 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  operand-valid; a/b sampled on every rising edge where start=1.
REQ-005 a  input  32  IEEE-754 binary32 multiplicand.
REQ-006 b  input  32  IEEE-754 binary32 multiplier.
REQ-007 result  output  32  binary32 product; registered; valid while done=1.
REQ-008 done  output  1  result-valid; one-cycle pulse per accepted operand pair.
REQ-009 overflow  output  1  product exceeded max finite; valid while done=1.
REQ-010 underflow  output  1  product below min normal and flushed to zero; valid while done=1.

Function
REQ-011 Fully pipelined: one operand pair accepted per cycle, no backpressure, no stall input.
REQ-012 Latency: a pair sampled at edge N with start=1 produces done=1, result and flags from edge N+4 until edge N+5.
REQ-013 Results emerge in acceptance order; consecutive start cycles yield consecutive done cycles.
REQ-014 Cycles with start=0 inject a bubble; the matching output cycle has done=0 and result/flags hold their previous values.
REQ-015 Stage 1: register inputs; unpack sign, exponent and mantissa; classify zero, infinity, NaN and denormal.
REQ-016 Stage 2: sign = sa XOR sb; exponent sum ea+eb-127 held at 10-bit signed width; 24x24 to 48-bit mantissa product with hidden bits.
REQ-017 Stage 3: normalize with 1-bit right shift if product bit 47 set (exponent+1); round to nearest, ties to even, using guard/round/sticky; renormalize on rounding carry-out.
REQ-018 Stage 4: pack, apply special-case overrides, and register result, done and flags.
REQ-019 Denormal inputs are treated as zero (flush-to-zero); denormal outputs are never produced.
REQ-020 Final exponent >= 255: result = signed infinity (sign,0xFF,0), overflow=1.
REQ-021 Final exponent <= 0: result = signed zero, underflow=1.
REQ-022 Either input NaN, or infinity times zero: result = 0x7FC00000, both flags 0.
REQ-023 Infinity times nonzero finite or infinity: signed infinity, both flags 0.
REQ-024 Zero times finite: signed zero, both flags 0.
REQ-025 Flags are mutually exclusive; both are 0 for any normal result.

Reset
REQ-026 While rst_n=0: result=0, done=0, overflow=0, underflow=0, and all stage-valid bits cleared, asynchronously.
REQ-027 Reset mid-operation discards all in-flight operands; no done pulse results from a pair accepted before reset.
REQ-028 The first pair accepted after reset release follows REQ-012 exactly.

Structure
REQ-029 A shared package fp32_pkg holds the binary32 field widths, BIAS=127, EXP_MAX=255, the QNAN=32'h7FC00000 constant, and a packed struct {sign, exp[7:0], man[22:0]}.
REQ-030 Rounding sits in one sub-module fp32_round_ne (48-bit mantissa plus exponent in; rounded 23-bit mantissa and adjusted exponent out), purely combinational.
REQ-031 No latches; multiplier inferred as a single 24x24 operator.

Verification
REQ-032 a=0x3FC00000 (1.5), b=0x40000000 (2.0), start one cycle -> done 4 cycles later, result=0x40400000, flags 0.
REQ-033 Back-to-back pairs (0x40400000,0xBF000000), (0x3F800000,0x3F800001), (0x00000000,0xC0000000) on 3 consecutive cycles -> 3 consecutive done cycles giving 0xBFC00000, 0x3F800001, 0x80000000.
REQ-034 a=b=0x7F000000 -> result=0x7F800000, overflow=1, underflow=0.
REQ-035 a=b=0x00800000 -> result=0x00000000, underflow=1, overflow=0.
REQ-036 a=0x7F800000, b=0x00000000 -> 0x7FC00000; a=0x7FC00001, b=0x3F800000 -> 0x7FC00000; flags 0 in both cases.
REQ-037 Start pairs then assert rst_n=0 two cycles later -> outputs zero immediately, no done pulse after release until new starts.
